wb_arbiter_2x1: RTL and testbench

- Shares one pipelined-Wishbone slave port between two masters: instruction fetch (imaster, wb_prefetch) and data load/store (dmaster).
- Grants whole bus tenures and tracks outstanding requests, so acks always return to the master that issued them.
- Enforces a tenure limit. The fetch unit holds cyc continuously while prefetching, so without it the data side would starve.
- Sits between the core's fetch/LSU masters and the memory interconnect.

---
 rtl/wb_arbiter_2x1_if.sv | 23 ++
 rtl/wb_arbiter_2x1.sv | 146 ++++++++++++++
 tb/tb_wb_arbiter_2x1.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_2x1_if.sv
// Pipelined Wishbone B4 bus bundle (32-bit data, 30-bit word address).
// MASTER is the side that issues requests; SLAVE is the side that answers them.
interface wishbone_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        stall;

    modport MASTER (
        output cyc, stb, we, sel, addr, wdata,
        input  rdata, ack, stall
    );

    modport SLAVE (
        input  cyc, stb, we, sel, addr, wdata,
        output rdata, ack, stall
    );
endinterface

// File: rtl/wb_arbiter_2x1.sv
// Two-master pipelined Wishbone arbiter: instruction fetch (imaster) and data (dmaster)
// share one downstream slave port. Whole tenures are granted, in-flight requests are
// counted so acks return to the issuing master, and a tenure limit stops the
// continuously-prefetching fetch unit from starving the data side.
module wb_arbiter_2x1 #(
    parameter int unsigned OUTSTANDING_POT = 3,
    parameter int unsigned MAX_HOLD        = 16
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    wishbone_if.SLAVE  imaster_if,
    wishbone_if.SLAVE  dmaster_if,
    wishbone_if.MASTER slave_if,
    output logic [1:0] grant_o
);

    localparam int unsigned CntW  = OUTSTANDING_POT + 1;
    localparam int unsigned HoldW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CntW-1:0]  CntFull = CntW'(1) << OUTSTANDING_POT;
    localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);
    localparam bit               HoldEn  = (MAX_HOLD != 0);

    typedef enum logic [1:0] {StIdle, StGrantI, StGrantD} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  outstanding_q, outstanding_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             last_grant_q, last_grant_d;  // 0 = imaster, 1 = dmaster

    logic             in_grant;
    logic             own_cyc, own_stb, own_we, other_cyc;
    logic [3:0]       own_sel;
    logic [29:0]      own_addr;
    logic [31:0]      own_wdata;
    logic             preempt, gate, accept, ack_hit;

    // Grant comes straight from the state register, so master cyc never reaches it
    // combinationally.
    assign grant_o  = {state_q == StGrantD, state_q == StGrantI};
    assign in_grant = (state_q != StIdle);

    // Select the current owner's request signals and the contender's cyc.
    always_comb begin
        own_cyc   = 1'b0;
        own_stb   = 1'b0;
        own_we    = 1'b0;
        own_sel   = '0;
        own_addr  = '0;
        own_wdata = '0;
        other_cyc = 1'b0;
        case (state_q)
            StGrantI: begin
                own_cyc   = imaster_if.cyc;
                own_stb   = imaster_if.stb;
                own_we    = imaster_if.we;
                own_sel   = imaster_if.sel;
                own_addr  = imaster_if.addr;
                own_wdata = imaster_if.wdata;
                other_cyc = dmaster_if.cyc;
            end
            StGrantD: begin
                own_cyc   = dmaster_if.cyc;
                own_stb   = dmaster_if.stb;
                own_we    = dmaster_if.we;
                own_sel   = dmaster_if.sel;
                own_addr  = dmaster_if.addr;
                own_wdata = dmaster_if.wdata;
                other_cyc = imaster_if.cyc;
            end
            default: ;
        endcase
    end

    // Routing to the slave and back to the masters; gate holds off new strobes when
    // the in-flight window is full or the tenure is being handed over.
    always_comb begin
        preempt = HoldEn && in_grant && (hold_cnt_q >= HoldMax) && other_cyc;
        gate    = (outstanding_q == CntFull) || preempt;

        slave_if.cyc   = in_grant && own_cyc;
        slave_if.stb   = in_grant && own_stb && !gate;
        slave_if.we    = own_we;
        slave_if.sel   = own_sel;
        slave_if.addr  = own_addr;
        slave_if.wdata = own_wdata;

        accept  = slave_if.cyc && slave_if.stb && !slave_if.stall;
        // Acks with nothing in flight are stale and must not underflow the counter.
        ack_hit = slave_if.ack && (outstanding_q != '0);

        imaster_if.stall = (state_q == StGrantI) ? (slave_if.stall || gate) : 1'b1;
        imaster_if.ack   = (state_q == StGrantI) ? slave_if.ack : 1'b0;
        imaster_if.rdata = slave_if.rdata;
        dmaster_if.stall = (state_q == StGrantD) ? (slave_if.stall || gate) : 1'b1;
        dmaster_if.ack   = (state_q == StGrantD) ? slave_if.ack : 1'b0;
        dmaster_if.rdata = slave_if.rdata;
    end

    // Next-state: arbitration in idle, counter/tenure bookkeeping and release in grant.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        hold_cnt_d    = hold_cnt_q;
        outstanding_d = '0;
        if (state_q == StIdle) begin
            hold_cnt_d = '0;
            if (imaster_if.cyc && dmaster_if.cyc) begin
                state_d = last_grant_q ? StGrantI : StGrantD;
            end else if (imaster_if.cyc) begin
                state_d = StGrantI;
            end else if (dmaster_if.cyc) begin
                state_d = StGrantD;
            end
        end else begin
            // Dropping cyc aborts the cycle; whatever is still in flight is forgotten.
            if (own_cyc) begin
                unique case ({accept, ack_hit})
                    2'b10:   outstanding_d = outstanding_q + CntW'(1);
                    2'b01:   outstanding_d = outstanding_q - CntW'(1);
                    default: outstanding_d = outstanding_q;
                endcase
            end
            hold_cnt_d = (hold_cnt_q == HoldMax) ? hold_cnt_q : hold_cnt_q + HoldW'(1);
            if ((!own_cyc || preempt) && (outstanding_d == '0)) begin
                state_d      = StIdle;
                last_grant_d = (state_q == StGrantD);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= StIdle;
            outstanding_q <= '0;
            hold_cnt_q    <= '0;
            last_grant_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            hold_cnt_q    <= hold_cnt_d;
            last_grant_q  <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2x1.sv
// Randomized bench for wb_arbiter_2x1 with a cycle-level reference model of the
// arbitration rules and a latency-queue slave responder.
module tb_wb_arbiter_2x1;

    localparam int unsigned POT   = 3;
    localparam int unsigned HOLD  = 16;
    localparam int          LIMIT = 1 << POT;
    localparam int          NCYC  = 3000;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] grant;

    always #5 clk = ~clk;

    wishbone_if ibus ();
    wishbone_if dbus ();
    wishbone_if sbus ();

    wb_arbiter_2x1 #(
        .OUTSTANDING_POT (POT),
        .MAX_HOLD        (HOLD)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .imaster_if (ibus),
        .dmaster_if (dbus),
        .slave_if   (sbus),
        .grant_o    (grant)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner 0 = none, 1 = imaster, 2 = dmaster.
    int m_owner = 0;
    int m_cnt   = 0;
    int m_hold  = 0;
    int m_last  = 1;

    int cyc_n   = 0;
    int ack_q[$];
    bit ack_en  = 1'b1;
    bit rst_done = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
        end
    endtask

    function automatic logic next_cyc(input logic cur);
        if (cur) return ($urandom_range(31) != 0);
        return ($urandom_range(3) == 0);
    endfunction

    task automatic model_reset();
        m_owner = 0;
        m_cnt   = 0;
        m_hold  = 0;
        m_last  = 1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_grant"}, 64'(grant), 64'd0);
        check_eq({tag, "_scyc"}, 64'(sbus.cyc), 64'd0);
        check_eq({tag, "_sstb"}, 64'(sbus.stb), 64'd0);
        check_eq({tag, "_istall"}, 64'(ibus.stall), 64'd1);
        check_eq({tag, "_dstall"}, 64'(dbus.stall), 64'd1);
        check_eq({tag, "_iack"}, 64'(ibus.ack), 64'd0);
        check_eq({tag, "_dack"}, 64'(dbus.ack), 64'd0);
    endtask

    task automatic drive_inputs(input int c);
        ibus.cyc   = next_cyc(ibus.cyc);
        ibus.stb   = ibus.cyc && ($urandom_range(3) != 0);
        ibus.we    = 1'($urandom_range(1));
        ibus.sel   = 4'($urandom);
        ibus.addr  = 30'($urandom);
        ibus.wdata = $urandom;
        dbus.cyc   = next_cyc(dbus.cyc);
        dbus.stb   = dbus.cyc && ($urandom_range(3) != 0);
        dbus.we    = 1'($urandom_range(1));
        dbus.sel   = 4'($urandom);
        dbus.addr  = 30'($urandom);
        dbus.wdata = $urandom;
        if (c == 0) begin
            ibus.cyc = 1'b1;
            dbus.cyc = 1'b1;
        end
        sbus.stall = ack_en ? ($urandom_range(3) == 0) : 1'b0;
        sbus.rdata = $urandom;
        sbus.ack   = 1'b0;
        if (ack_en && ack_q.size() > 0 && ack_q[0] <= cyc_n) begin
            sbus.ack = 1'b1;
            ack_q.delete(0);
        end
    endtask

    task automatic check_and_step();
        logic        o_cyc, o_stb, o_we, oth, pre, blk, e_scyc, e_sstb, acc, ackd;
        logic [3:0]  o_sel;
        logic [29:0] o_addr;
        logic [31:0] o_wdata;
        int          nxt;
        o_cyc = 0; o_stb = 0; o_we = 0; oth = 0; o_sel = 0; o_addr = 0; o_wdata = 0;
        if (m_owner == 1) begin
            o_cyc = ibus.cyc; o_stb = ibus.stb; o_we = ibus.we; o_sel = ibus.sel;
            o_addr = ibus.addr; o_wdata = ibus.wdata; oth = dbus.cyc;
        end else if (m_owner == 2) begin
            o_cyc = dbus.cyc; o_stb = dbus.stb; o_we = dbus.we; o_sel = dbus.sel;
            o_addr = dbus.addr; o_wdata = dbus.wdata; oth = ibus.cyc;
        end
        pre    = (m_owner != 0) && (HOLD != 0) && (m_hold >= HOLD) && oth;
        blk    = (m_cnt == LIMIT) || pre;
        e_scyc = (m_owner != 0) && o_cyc;
        e_sstb = (m_owner != 0) && o_stb && !blk;

        check_eq("grant", 64'(grant), 64'(m_owner == 1 ? 1 : (m_owner == 2 ? 2 : 0)));
        check_eq("slave_cyc", 64'(sbus.cyc), 64'(e_scyc));
        check_eq("slave_stb", 64'(sbus.stb), 64'(e_sstb));
        check_eq("i_stall", 64'(ibus.stall), 64'(m_owner == 1 ? (sbus.stall || blk) : 1'b1));
        check_eq("d_stall", 64'(dbus.stall), 64'(m_owner == 2 ? (sbus.stall || blk) : 1'b1));
        check_eq("i_ack", 64'(ibus.ack), 64'(m_owner == 1 ? sbus.ack : 1'b0));
        check_eq("d_ack", 64'(dbus.ack), 64'(m_owner == 2 ? sbus.ack : 1'b0));
        check_eq("i_rdata", 64'(ibus.rdata), 64'(sbus.rdata));
        check_eq("d_rdata", 64'(dbus.rdata), 64'(sbus.rdata));
        if (e_sstb) begin
            check_eq("slave_req", {sbus.we, sbus.sel, sbus.addr}, {o_we, o_sel, o_addr});
            check_eq("slave_wdata", 64'(sbus.wdata), 64'(o_wdata));
        end

        acc  = e_sstb && !sbus.stall;
        ackd = sbus.ack && (m_cnt > 0);
        if (acc) ack_q.push_back(cyc_n + $urandom_range(1, 3));

        if (m_owner == 0) begin
            m_hold = 0;
            if (ibus.cyc && dbus.cyc) m_owner = (m_last == 1) ? 2 : 1;
            else if (ibus.cyc)        m_owner = 1;
            else if (dbus.cyc)        m_owner = 2;
        end else begin
            nxt = o_cyc ? (m_cnt + (acc ? 1 : 0) - (ackd ? 1 : 0)) : 0;
            m_cnt  = nxt;
            m_hold = (m_hold + 1 > HOLD) ? HOLD : m_hold + 1;
            if ((!o_cyc || pre) && nxt == 0) begin
                m_last  = m_owner;
                m_owner = 0;
            end
        end
        cyc_n++;
    endtask

    initial begin
        ibus.cyc = 0; ibus.stb = 0; ibus.we = 0; ibus.sel = 0; ibus.addr = 0; ibus.wdata = 0;
        dbus.cyc = 0; dbus.stb = 0; dbus.we = 0; dbus.sel = 0; dbus.addr = 0; dbus.wdata = 0;
        sbus.stall = 0; sbus.ack = 0; sbus.rdata = 0;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        for (int c = 0; c < NCYC; c++) begin
            // Window with a silent slave so the in-flight limit is reached.
            ack_en = !(c >= 1200 && c < 1500);
            @(posedge clk);
            #1;
            if (!rstn) rstn = 1'b1;
            drive_inputs(c);
            @(negedge clk);
            check_and_step();
            // One asynchronous reset in the middle of a burst.
            if (c >= 2000 && !rst_done && m_cnt >= 2) begin
                #2 rstn = 1'b0;
                #1;
                check_idle_outputs("midreset");
                model_reset();
                rst_done = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
